// File: rtl/stream_mux2_rr.sv
// 2-to-1 valid/ready stream mux with round-robin arbitration and one registered output stage.
// Define STREAM_MUX2_PACKET_LOCK_EN to add last flags and hold the grant until a packet ends.
module stream_mux2_rr #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in0_data,
    input  logic             in0_valid,
    output logic             in0_ready,
`ifdef STREAM_MUX2_PACKET_LOCK_EN
    input  logic             in0_last,
`endif
    input  logic [WIDTH-1:0] in1_data,
    input  logic             in1_valid,
    output logic             in1_ready,
`ifdef STREAM_MUX2_PACKET_LOCK_EN
    input  logic             in1_last,
    output logic             out_last,
`endif
    output logic [WIDTH-1:0] out_data,
    output logic             out_sel,
    output logic             out_valid,
    input  logic             out_ready
);

    logic [WIDTH-1:0] out_data_q;
    logic             out_sel_q;
    logic             out_valid_q;
    logic             prio_q;

    logic load;
    logic rr_grant0;
    logic rr_grant1;
    logic grant0;
    logic grant1;
    logic accept0;
    logic accept1;

`ifdef STREAM_MUX2_PACKET_LOCK_EN
    typedef enum logic [1:0] {
        StArb,
        StLock0,
        StLock1
    } state_e;

    state_e state_q;
    logic   out_last_q;
`endif

    always_comb begin
        load = ~out_valid_q | out_ready;

        if (in0_valid && in1_valid) begin
            rr_grant0 = ~prio_q;
            rr_grant1 = prio_q;
        end else begin
            rr_grant0 = in0_valid;
            rr_grant1 = in1_valid;
        end

`ifdef STREAM_MUX2_PACKET_LOCK_EN
        // Mid-packet, the locked source owns the output even if the other is waiting.
        case (state_q)
            StLock0: begin
                grant0 = in0_valid;
                grant1 = 1'b0;
            end
            StLock1: begin
                grant0 = 1'b0;
                grant1 = in1_valid;
            end
            default: begin
                grant0 = rr_grant0;
                grant1 = rr_grant1;
            end
        endcase
`else
        grant0 = rr_grant0;
        grant1 = rr_grant1;
`endif

        // Gating with reset keeps a source from seeing a handshake that the flush discards.
        in0_ready = load & grant0 & ~reset;
        in1_ready = load & grant1 & ~reset;
        accept0   = in0_valid & in0_ready;
        accept1   = in1_valid & in1_ready;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_data_q  <= '0;
            out_sel_q   <= 1'b0;
            out_valid_q <= 1'b0;
            prio_q      <= 1'b0;
`ifdef STREAM_MUX2_PACKET_LOCK_EN
            out_last_q  <= 1'b0;
            state_q     <= StArb;
`endif
        end else if (load) begin
            if (accept0) begin
                out_data_q  <= in0_data;
                out_sel_q   <= 1'b0;
                out_valid_q <= 1'b1;
`ifdef STREAM_MUX2_PACKET_LOCK_EN
                out_last_q  <= in0_last;
                if (in0_last) begin
                    prio_q  <= 1'b1;
                    state_q <= StArb;
                end else begin
                    state_q <= StLock0;
                end
`else
                prio_q      <= 1'b1;
`endif
            end else if (accept1) begin
                out_data_q  <= in1_data;
                out_sel_q   <= 1'b1;
                out_valid_q <= 1'b1;
`ifdef STREAM_MUX2_PACKET_LOCK_EN
                out_last_q  <= in1_last;
                if (in1_last) begin
                    prio_q  <= 1'b0;
                    state_q <= StArb;
                end else begin
                    state_q <= StLock1;
                end
`else
                prio_q      <= 1'b0;
`endif
            end else begin
                // Payload is held; only the valid flag drops so a drained beat is not replayed.
                out_valid_q <= 1'b0;
            end
        end
    end

    assign out_data  = out_data_q;
    assign out_sel   = out_sel_q;
    assign out_valid = out_valid_q;
`ifdef STREAM_MUX2_PACKET_LOCK_EN
    assign out_last  = out_last_q;
`endif

endmodule

// File: tb/tb_stream_mux2_rr.sv
// Scoreboard bench for stream_mux2_rr: directed source queues feed the DUT and a
// negedge monitor pops expected {sel,data} beats on every output handshake.
module tb_stream_mux2_rr;

    localparam int unsigned WIDTH = 16;

    logic             clk = 1'b0;
    logic             reset;
    logic [WIDTH-1:0] in0_data;
    logic             in0_valid;
    logic             in0_ready;
    logic [WIDTH-1:0] in1_data;
    logic             in1_valid;
    logic             in1_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_sel;
    logic             out_valid;
    logic             out_ready;
`ifdef STREAM_MUX2_PACKET_LOCK_EN
    logic             in0_last;
    logic             in1_last;
    logic             out_last;
`endif

    stream_mux2_rr #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .in0_data  (in0_data),
        .in0_valid (in0_valid),
        .in0_ready (in0_ready),
`ifdef STREAM_MUX2_PACKET_LOCK_EN
        .in0_last  (in0_last),
`endif
        .in1_data  (in1_data),
        .in1_valid (in1_valid),
        .in1_ready (in1_ready),
`ifdef STREAM_MUX2_PACKET_LOCK_EN
        .in1_last  (in1_last),
        .out_last  (out_last),
`endif
        .out_data  (out_data),
        .out_sel   (out_sel),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    int hs_n  = 0;
    int hs_first = 0;
    int hs_last  = 0;

    // Source entries are {last, data}; expected entries are {sel, data}.
    logic [16:0] src0[$];
    logic [16:0] src1[$];
    logic [16:0] exp_q[$];

    function automatic void check(string name, logic [31:0] act, logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        logic [16:0] e;
        if (!reset && out_valid === 1'b1 && out_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_beat", 32'({out_sel, out_data}), 32'h1_dead);
            end else begin
                e = exp_q.pop_front();
                check("scoreboard_beat", 32'({out_sel, out_data}), 32'(e));
            end
            if (hs_n == 0) hs_first = cyc;
            hs_last = cyc;
            hs_n++;
        end
    end

    task automatic drive();
        logic [16:0] t;
        in0_valid = (src0.size() != 0);
        t = in0_valid ? src0[0] : 17'h0;
        in0_data = t[15:0];
`ifdef STREAM_MUX2_PACKET_LOCK_EN
        in0_last = t[16];
`endif
        in1_valid = (src1.size() != 0);
        t = in1_valid ? src1[0] : 17'h0;
        in1_data = t[15:0];
`ifdef STREAM_MUX2_PACKET_LOCK_EN
        in1_last = t[16];
`endif
    endtask

    // One clock: sample source handshakes at negedge, retire them after the edge.
    task automatic cycle();
        logic f0;
        logic f1;
        @(negedge clk);
        f0 = in0_valid && in0_ready && !reset;
        f1 = in1_valid && in1_ready && !reset;
        @(posedge clk);
        #1;
        if (f0) void'(src0.pop_front());
        if (f1) void'(src1.pop_front());
        drive();
    endtask

    task automatic drain(string name);
        bit done = 0;
        for (int i = 0; i < 200; i++) begin
            done = (src0.size() == 0) && (src1.size() == 0) && (exp_q.size() == 0);
            if (done) break;
            cycle();
        end
        check(name, 32'(done), 32'd1);
    endtask

    initial begin
        out_ready = 1'b1;
        reset     = 1'b1;

        // Reset held two cycles with both sources valid.
        src0.push_back({1'b0, 16'h1111});
        src1.push_back({1'b0, 16'h2222});
        drive();
        for (int i = 0; i < 2; i++) begin
            cycle();
            check("rst_in0_ready", 32'(in0_ready), 32'd0);
            check("rst_in1_ready", 32'(in1_ready), 32'd0);
            check("rst_out_valid", 32'(out_valid), 32'd0);
            check("rst_out_data", 32'(out_data), 32'd0);
            check("rst_out_sel", 32'(out_sel), 32'd0);
        end
        reset = 1'b0;
        exp_q.push_back({1'b0, 16'h1111});
        exp_q.push_back({1'b1, 16'h2222});
        drain("rst_drain");

        // Single source: 1-cycle latency, no gaps. prio ends at 0 after in1 beat above.
        hs_n = 0;
        for (int i = 1; i <= 3; i++) begin
            src0.push_back({1'b0, 16'(i)});
            exp_q.push_back({1'b0, 16'(i)});
        end
        drive();
        cycle();
        check("single_latency_valid", 32'(out_valid), 32'd1);
        check("single_latency_data", 32'(out_data), 32'h0001);
        drain("single_drain");
        check("single_count", 32'(hs_n), 32'd3);
        check("single_no_gap", 32'(hs_last - hs_first), 32'd2);

        // Contention: last accept was in0, so in1 leads and the tag alternates.
        hs_n = 0;
        for (int i = 0; i < 4; i++) begin
            src0.push_back({1'b0, 16'hA000 + 16'(i)});
            src1.push_back({1'b0, 16'hB000 + 16'(i)});
            exp_q.push_back({1'b1, 16'hB000 + 16'(i)});
            exp_q.push_back({1'b0, 16'hA000 + 16'(i)});
        end
        drive();
        drain("contend_drain");
        check("contend_count", 32'(hs_n), 32'd8);
        check("contend_no_gap", 32'(hs_last - hs_first), 32'd7);

        // Backpressure: hold the first beat (D0 from in1) for three stalled cycles.
        hs_n = 0;
        for (int i = 0; i < 3; i++) begin
            src0.push_back({1'b0, 16'hC000 + 16'(i)});
            src1.push_back({1'b0, 16'hD000 + 16'(i)});
            exp_q.push_back({1'b1, 16'hD000 + 16'(i)});
            exp_q.push_back({1'b0, 16'hC000 + 16'(i)});
        end
        drive();
        cycle();
        out_ready = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            check("stall_in0_ready", 32'(in0_ready), 32'd0);
            check("stall_in1_ready", 32'(in1_ready), 32'd0);
            cycle();
            check("stall_valid", 32'(out_valid), 32'd1);
            check("stall_beat", 32'({out_sel, out_data}), 32'h1_d000);
        end
        out_ready = 1'b1;
        drain("stall_drain");
        check("stall_count", 32'(hs_n), 32'd6);

        // Reset during a stall drops the held F0 and restores in0 priority.
        src0.push_back({1'b0, 16'hE000});
        src0.push_back({1'b0, 16'hE001});
        src1.push_back({1'b0, 16'hF000});
        src1.push_back({1'b0, 16'hF001});
        drive();
        cycle();
        check("midrst_held_beat", 32'({out_sel, out_data}), 32'h1_f000);
        out_ready = 1'b0;
        cycle();
        reset = 1'b1;
        cycle();
        check("midrst_valid", 32'(out_valid), 32'd0);
        check("midrst_data", 32'(out_data), 32'd0);
        reset     = 1'b0;
        out_ready = 1'b1;
        exp_q.push_back({1'b0, 16'hE000});
        exp_q.push_back({1'b1, 16'hF001});
        exp_q.push_back({1'b0, 16'hE001});
        cycle();
        check("midrst_first_beat", 32'({out_valid, out_sel, out_data}), 32'h2_e000);
        drain("midrst_drain");

`ifdef STREAM_MUX2_PACKET_LOCK_EN
        // Packet lock: in1 waits until in0's 3-beat packet completes.
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        src0.push_back({1'b0, 16'h5000});
        src0.push_back({1'b0, 16'h5001});
        src0.push_back({1'b1, 16'h5002});
        src1.push_back({1'b1, 16'h6000});
        src1.push_back({1'b1, 16'h6001});
        exp_q.push_back({1'b0, 16'h5000});
        exp_q.push_back({1'b0, 16'h5001});
        exp_q.push_back({1'b0, 16'h5002});
        exp_q.push_back({1'b1, 16'h6000});
        exp_q.push_back({1'b1, 16'h6001});
        drive();
        for (int k = 0; k < 3; k++) begin
            check("lock_in1_blocked", 32'(in1_ready), 32'd0);
            cycle();
            check("lock_out_last", 32'(out_last), 32'(k == 2));
        end
        check("lock_release", 32'(in1_ready), 32'd1);
        drain("lock_drain");
`endif

        check("final_queue_empty", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
